// File: rtl/imem_dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// imem_dmem_port_arbiter
//
// Purpose:
//   Shares one single-ported memory between instruction fetch (IF) and the
//   data stage (MEM). Only one transaction is outstanding at a time. Data
//   wins contested cycles unless IF has lost STARVE_MAX contested
//   arbitrations in a row, in which case IF is forced through.
//
// Parameters:
//   AW          address width
//   DW          data width
//   STARVE_MAX  contested data wins before IF is forced (0 = IF wins ties)
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_req/if_addr           IF read request and word address
//   if_gnt/if_rvalid/if_rdata  IF accept pulse, response pulse, read data
//   d_req/d_we/d_addr/d_wdata  data request, store flag, address, store data
//   d_gnt/d_rvalid/d_rdata   data accept pulse, response pulse, load data
//   mem_req/mem_we/mem_addr/mem_wdata  registered request to memory
//   mem_gnt/mem_rvalid/mem_rdata       memory accept, response, read data
//   conflict_cnt             count of contested IDLE cycles (optional)
//   arb_busy                 high whenever a transaction is in flight
//
// Configuration:
//   ARB_PERF_CNT_EN  when defined, adds the 32-bit conflict_cnt output.
// ---------------------------------------------------------------------------
module imem_dmem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0]   conflict_cnt,
`endif
    output logic          arb_busy
);

    // A zero-width counter is illegal, so STARVE_MAX=0 still gets one bit.
    localparam int CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t        state_q;
    logic          owner_data_q;
    logic [CW-1:0] starve_cnt_q;
    logic [CW-1:0] starve_cnt_d;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;

    logic          pick_data;
    logic          pick_if;
    logic          accept;
    logic [AW-1:0] win_addr;

    // Arbitration: data wins unless IF is also asking and has been starved.
    // Grants are suppressed during reset so no accepted request is lost.
    always_comb begin
        pick_data = d_req & ~(if_req & (starve_cnt_q >= STARVE_LIM));
        pick_if   = if_req & ~pick_data;
        accept    = (state_q == IDLE) & ~rst & (if_req | d_req);
        win_addr  = (pick_data ? d_addr : if_addr) & {{(AW-2){1'b1}}, 2'b00};
    end

    // Starvation counter: counts data grants that IF lost, cleared on IF grant.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (if_gnt) begin
            starve_cnt_d = '0;
        end else if (d_gnt && if_req && (starve_cnt_q < STARVE_LIM)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    // Transaction FSM; latches the winner's request on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_data_q <= 1'b0;
            starve_cnt_q <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        owner_data_q <= pick_data;
                        mem_we_q     <= pick_data & d_we;
                        mem_addr_q   <= win_addr;
                        mem_wdata_q  <= pick_data ? d_wdata : '0;
                        state_q      <= REQ;
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        state_q <= RSP;
                    end
                end
                RSP: begin
                    if (mem_rvalid) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Responses route only to the latched owner; a response arriving in the
    // reset cycle is dropped because the transaction is being abandoned.
    assign if_gnt    = accept & pick_if;
    assign d_gnt     = accept & pick_data;
    assign if_rvalid = (state_q == RSP) & mem_rvalid & ~owner_data_q & ~rst;
    assign d_rvalid  = (state_q == RSP) & mem_rvalid & owner_data_q & ~rst;
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign mem_req   = (state_q == REQ);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign arb_busy  = (state_q != IDLE);

`ifdef ARB_PERF_CNT_EN
    logic [31:0] conflict_cnt_q;
    logic [31:0] conflict_cnt_d;

    // Contested IDLE cycles; wraps naturally at 2^32.
    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if ((state_q == IDLE) && if_req && d_req) begin
            conflict_cnt_d = conflict_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt_q <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_imem_dmem_port_arbiter
//
// Purpose:
//   Directed, table-driven bench for imem_dmem_port_arbiter. Each record is
//   one clock cycle of inputs plus the outputs expected in that cycle.
//   Honours ARB_PERF_CNT_EN for the optional conflict counter.
// ---------------------------------------------------------------------------
module tb_imem_dmem_port_arbiter;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    typedef struct {
        logic        rst;
        logic        ifReq;
        logic [31:0] ifAddr;
        logic        dReq;
        logic        dWe;
        logic [31:0] dAddr;
        logic [31:0] dWdata;
        logic        memGnt;
        logic        memRvalid;
        logic [31:0] memRdata;
        logic        expIfGnt;
        logic        expIfRvalid;
        logic        expDGnt;
        logic        expDRvalid;
        logic        expMemReq;
        logic        expMemWe;
        logic        expBusy;
        logic [31:0] expMemAddr;
        logic [31:0] expMemWdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifReq = 1'b0;
    logic [31:0] ifAddr = '0;
    logic        ifGnt;
    logic        ifRvalid;
    logic [31:0] ifRdata;
    logic        dReq = 1'b0;
    logic        dWe = 1'b0;
    logic [31:0] dAddr = '0;
    logic [31:0] dWdata = '0;
    logic        dGnt;
    logic        dRvalid;
    logic [31:0] dRdata;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic        memGnt = 1'b0;
    logic        memRvalid = 1'b0;
    logic [31:0] memRdata = '0;
    logic        arbBusy;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] conflictCnt;
`endif

    int compared = 0;
    int mismatched = 0;

    vec_t vecs[$];

    always #5 clk = ~clk;

    imem_dmem_port_arbiter #(
        .AW(32),
        .DW(32),
        .STARVE_MAX(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .if_req(ifReq),
        .if_addr(ifAddr),
        .if_gnt(ifGnt),
        .if_rvalid(ifRvalid),
        .if_rdata(ifRdata),
        .d_req(dReq),
        .d_we(dWe),
        .d_addr(dAddr),
        .d_wdata(dWdata),
        .d_gnt(dGnt),
        .d_rvalid(dRvalid),
        .d_rdata(dRdata),
        .mem_req(memReq),
        .mem_we(memWe),
        .mem_addr(memAddr),
        .mem_wdata(memWdata),
        .mem_gnt(memGnt),
        .mem_rvalid(memRvalid),
        .mem_rdata(memRdata),
`ifdef ARB_PERF_CNT_EN
        .conflict_cnt(conflictCnt),
`endif
        .arb_busy(arbBusy)
    );

    // Builds one cycle record: inputs first, then the expected outputs.
    function automatic vec_t mkVec(
        input logic r, input logic ir, input logic [31:0] ia,
        input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
        input logic mg, input logic mrv, input logic [31:0] mrd,
        input logic eIg, input logic eIrv, input logic eDg, input logic eDrv,
        input logic eReq, input logic eWe, input logic eBusy,
        input logic [31:0] eAddr, input logic [31:0] eWd);
        vec_t v;
        v.rst = r;  v.ifReq = ir;  v.ifAddr = ia;
        v.dReq = dr;  v.dWe = dw;  v.dAddr = da;  v.dWdata = dd;
        v.memGnt = mg;  v.memRvalid = mrv;  v.memRdata = mrd;
        v.expIfGnt = eIg;  v.expIfRvalid = eIrv;  v.expDGnt = eDg;  v.expDRvalid = eDrv;
        v.expMemReq = eReq;  v.expMemWe = eWe;  v.expBusy = eBusy;
        v.expMemAddr = eAddr;  v.expMemWdata = eWd;
        return v;
    endfunction

    // Drives one cycle's inputs on the falling edge.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst       = v.rst;
        ifReq     = v.ifReq;
        ifAddr    = v.ifAddr;
        dReq      = v.dReq;
        dWe       = v.dWe;
        dAddr     = v.dAddr;
        dWdata    = v.dWdata;
        memGnt    = v.memGnt;
        memRvalid = v.memRvalid;
        memRdata  = v.memRdata;
    endtask

    // Compares outputs shortly after the inputs settle, well before the rising edge.
    task automatic checkOutput(input vec_t v, input string name);
        logic [70:0] got;
        logic [70:0] exp;
        #1;
        got = {ifGnt, ifRvalid, dGnt, dRvalid, memReq, memWe, arbBusy, memAddr, memWdata};
        exp = {v.expIfGnt, v.expIfRvalid, v.expDGnt, v.expDRvalid, v.expMemReq,
               v.expMemWe, v.expBusy, v.expMemAddr, v.expMemWdata};
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s outputs {ig,irv,dg,drv,req,we,busy,addr,wdata} got=%h exp=%h",
                     name, got, exp);
        end
        if (v.expIfRvalid) begin
            compared++;
            if (ifRdata !== v.memRdata) begin
                mismatched++;
                $display("[TB] FAIL %s if_rdata got=%h exp=%h", name, ifRdata, v.memRdata);
            end
        end
        if (v.expDRvalid) begin
            compared++;
            if (dRdata !== v.memRdata) begin
                mismatched++;
                $display("[TB] FAIL %s d_rdata got=%h exp=%h", name, dRdata, v.memRdata);
            end
        end
    endtask

    initial begin
        logic        isIf;
        logic [31:0] curAddr;
        logic [31:0] prevAddr;

        // Reset, then a single fetch; memory strobes in IDLE must be ignored.
        vecs.push_back(mkVec(H, L, 32'h0,  L, L, 32'h0, 32'h0, L, L, 32'h0,        L, L, L, L, L, L, L, 32'h0,  32'h0));
        vecs.push_back(mkVec(L, H, 32'h10, L, L, 32'h0, 32'h0, H, H, 32'h0,        H, L, L, L, L, L, L, 32'h0,  32'h0));
        vecs.push_back(mkVec(L, L, 32'h10, L, L, 32'h0, 32'h0, H, L, 32'h0,        L, L, L, L, H, L, H, 32'h10, 32'h0));
        vecs.push_back(mkVec(L, L, 32'h10, L, L, 32'h0, 32'h0, L, H, 32'hDEADBEEF, L, H, L, L, L, L, H, 32'h10, 32'h0));
        vecs.push_back(mkVec(L, L, 32'h10, L, L, 32'h0, 32'h0, L, L, 32'h0,        L, L, L, L, L, L, L, 32'h10, 32'h0));

        // Both requesters held: grant order D,D,D,D,IF,D with an immediate memory.
        prevAddr = 32'h10;
        for (int g = 0; g < 6; g++) begin
            isIf    = (g == 4);
            curAddr = isIf ? 32'h100 : 32'h200;
            vecs.push_back(mkVec(L, H, 32'h100, H, L, 32'h200, 32'h0, H, H, 32'h1234,
                                 isIf, L, ~isIf, L, L, L, L, prevAddr, 32'h0));
            vecs.push_back(mkVec(L, H, 32'h100, H, L, 32'h200, 32'h0, H, H, 32'h1234,
                                 L, L, L, L, H, L, H, curAddr, 32'h0));
            vecs.push_back(mkVec(L, H, 32'h100, H, L, 32'h200, 32'h0, H, H, 32'h1234,
                                 L, isIf, L, ~isIf, L, L, H, curAddr, 32'h0));
            prevAddr = curAddr;
        end

        // Data store: registered we/addr/wdata, ack goes to data only.
        vecs.push_back(mkVec(L, L, 32'h0, H, H, 32'h2004, 32'h55AA, L, L, 32'h0,  L, L, H, L, L, L, L, 32'h200,  32'h0));
        vecs.push_back(mkVec(L, L, 32'h0, L, L, 32'h0,    32'h0,    H, L, 32'h0,  L, L, L, L, H, H, H, 32'h2004, 32'h55AA));
        vecs.push_back(mkVec(L, L, 32'h0, L, L, 32'h0,    32'h0,    L, H, 32'h77, L, L, L, H, L, H, H, 32'h2004, 32'h55AA));
        vecs.push_back(mkVec(L, L, 32'h0, L, L, 32'h0,    32'h0,    L, L, 32'h0,  L, L, L, L, L, H, L, 32'h2004, 32'h55AA));

        // Memory stall for 5 cycles with a pending IF request and spurious rvalid.
        vecs.push_back(mkVec(L, L, 32'h0, H, L, 32'h3008, 32'h0, L, L, 32'h0, L, L, H, L, L, H, L, 32'h2004, 32'h55AA));
        for (int s = 0; s < 5; s++) begin
            vecs.push_back(mkVec(L, H, 32'h47, L, L, 32'h0, 32'h0, L, H, 32'h0, L, L, L, L, H, L, H, 32'h3008, 32'h0));
        end
        vecs.push_back(mkVec(L, H, 32'h47, L, L, 32'h0, 32'h0, H, L, 32'h0,    L, L, L, L, H, L, H, 32'h3008, 32'h0));
        vecs.push_back(mkVec(L, H, 32'h47, L, L, 32'h0, 32'h0, L, H, 32'hCAFE, L, L, L, H, L, L, H, 32'h3008, 32'h0));
        // Unaligned fetch address has its low bits cleared on mem_addr.
        vecs.push_back(mkVec(L, H, 32'h47, L, L, 32'h0, 32'h0, L, L, 32'h0,    H, L, L, L, L, L, L, 32'h3008, 32'h0));

        // Reset while in RSP: no rvalid, everything back to reset values.
        vecs.push_back(mkVec(L, L, 32'h0,  L, L, 32'h0, 32'h0, H, L, 32'h0,    L, L, L, L, H, L, H, 32'h44, 32'h0));
        vecs.push_back(mkVec(H, L, 32'h0,  L, L, 32'h0, 32'h0, L, H, 32'hBAD,  L, L, L, L, L, L, H, 32'h44, 32'h0));
        vecs.push_back(mkVec(L, L, 32'h0,  L, L, 32'h0, 32'h0, L, H, 32'hBAD,  L, L, L, L, L, L, L, 32'h0,  32'h0));
        vecs.push_back(mkVec(L, H, 32'h80, L, L, 32'h0, 32'h0, L, L, 32'h0,    H, L, L, L, L, L, L, 32'h0,  32'h0));
        vecs.push_back(mkVec(L, L, 32'h0,  L, L, 32'h0, 32'h0, H, L, 32'h0,    L, L, L, L, H, L, H, 32'h80, 32'h0));
        vecs.push_back(mkVec(L, L, 32'h0,  L, L, 32'h0, 32'h0, L, H, 32'h600D, L, H, L, L, L, L, H, 32'h80, 32'h0));
        vecs.push_back(mkVec(L, L, 32'h0,  L, L, 32'h0, 32'h0, L, L, 32'h0,    L, L, L, L, L, L, L, 32'h80, 32'h0));

        $display("[TB] applying %0d table vectors", vecs.size());
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset asserted while waiting for mem_gnt: mem_req still high that
        // cycle, gone the next, and the latched store is cleared.
        begin
            vec_t v;
            v = mkVec(L, L, 32'h0, H, H, 32'h400, 32'h99, L, L, 32'h0, L, L, H, L, L, L, L, 32'h80, 32'h0);
            applyStimulus(v);  checkOutput(v, "rstReq.grant");
            v = mkVec(H, L, 32'h0, L, L, 32'h0, 32'h0, L, L, 32'h0, L, L, L, L, H, H, H, 32'h400, 32'h99);
            applyStimulus(v);  checkOutput(v, "rstReq.inReset");
            v = mkVec(L, L, 32'h0, L, L, 32'h0, 32'h0, H, H, 32'h0, L, L, L, L, L, L, L, 32'h0, 32'h0);
            applyStimulus(v);  checkOutput(v, "rstReq.after");
        end

`ifdef ARB_PERF_CNT_EN
        // Ten cycles of contention with an immediate memory: IDLE occurs on
        // cycles 0, 3, 6 and 9, so four conflicts are counted.
        begin
            vec_t v;
            v = mkVec(H, L, 32'h0, L, L, 32'h0, 32'h0, L, L, 32'h0, L, L, L, L, L, L, L, 32'h0, 32'h0);
            applyStimulus(v);  checkOutput(v, "perf.reset");
            compared++;
            if (conflictCnt !== 32'd0) begin
                mismatched++;
                $display("[TB] FAIL perf.resetCnt conflict_cnt got=%0d exp=0", conflictCnt);
            end
            v = mkVec(L, H, 32'h100, H, L, 32'h200, 32'h0, H, H, 32'h0, L, L, L, L, L, L, L, 32'h0, 32'h0);
            for (int c = 0; c < 10; c++) begin
                applyStimulus(v);
            end
            v = mkVec(L, L, 32'h0, L, L, 32'h0, 32'h0, H, H, 32'h0, L, L, L, L, H, L, H, 32'h200, 32'h0);
            applyStimulus(v);  checkOutput(v, "perf.drain");
            compared++;
            if (conflictCnt !== 32'd4) begin
                mismatched++;
                $display("[TB] FAIL perf.count conflict_cnt got=%0d exp=4", conflictCnt);
            end
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
